// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler and serializer.
package uart_pkg;

    localparam int unsigned DATA_W            = 8;
    localparam int unsigned UART_FRAME_CYCLES = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FRAME  = 2'd2,
        GAP    = 2'd3
    } sched_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake and serializer-side launch bus of the scheduler.
interface uart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDX_W = uart_pkg::idx_w(NUM_REQ);
    localparam int unsigned DW    = uart_pkg::DATA_W;

    logic [NUM_REQ-1:0]    req_valid;
    logic [DW*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  ser_enable;
    logic [DW-1:0]         ser_data;
    logic [IDX_W-1:0]      grant_id;
    logic                  busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, ser_enable, ser_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, ser_enable, ser_data, grant_id, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [2*NUM_REQ-1:0] dbl_sh;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [SUM_W-1:0]     off;
    logic [SUM_W-1:0]     sum;

    // Rotate requests so bit 0 is the pointer slot, pick the lowest offset, map back.
    always_comb begin
        dbl_sh = {req, req} >> ptr;
        rot    = dbl_sh[NUM_REQ-1:0];
        found  = 1'b0;
        off    = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = SUM_W'(k);
            end
        end
        sum = SUM_W'(ptr) + off;
        if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
        end
        gnt_idx = sum[IDX_W-1:0];
        gnt     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            gnt[i] = en && found && (sum == SUM_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmit serializer among NUM_REQ byte producers with frame pacing.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned FRAME_CYCLES = UART_FRAME_CYCLES,
    parameter int unsigned GAP_CYCLES   = 0
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_sched_if.slave bus
);

    localparam int unsigned IDX_W      = idx_w(NUM_REQ);
    localparam int unsigned CNT_MAX    = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned FRAME_LOAD = (FRAME_CYCLES > 0) ? FRAME_CYCLES - 1 : 0;
    localparam int unsigned GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sched_state_e       state_q;
    sched_state_e       state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [DATA_W-1:0]  hold_q;
    logic [IDX_W-1:0]   gid_q;
    logic               en_q;
    logic               busy_q;
    logic               arb_en;
    logic               xfer;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  sel_data;

    // Arbitration is only offered while idle and not being reset.
    assign arb_en = (state_q == IDLE) && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Select the winner's byte with a one-hot OR mux.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and counter logic; counter always exits at zero, never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                xfer = |gnt;
                if (xfer) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = FRAME;
                cnt_d   = CNT_W'(FRAME_LOAD);
            end
            FRAME: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_LOAD);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d == LAUNCH);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Hold register, last grant and rotating priority pointer update on transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            hold_q <= '0;
            gid_q  <= '0;
        end else if (xfer) begin
            hold_q <= sel_data;
            gid_q  <= gnt_idx;
            ptr_q  <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.ser_enable = en_q;
    assign bus.ser_data   = hold_q;
    assign bus.grant_id   = gid_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: timeline model checked every cycle plus directed literals.
module tb_uart_tx_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned F  = 11;
    localparam int unsigned G1 = 5;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset1 = 1'b1;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched_if #(.NUM_REQ(N)) b0 ();
    uart_tx_sched_if #(.NUM_REQ(N)) b1 ();

    uart_tx_sched #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    uart_tx_sched #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (b1)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit done1  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // Model: the last transfer cycle and the earliest cycle of the next one define everything.
    bit           chk_on = 1'b0;
    int           t_x    = -100;
    int           nfree  = 0;
    int           ptr_m  = 0;
    int           gid_m  = 0;
    logic [7:0]   hold_m = 8'h00;
    logic [N-1:0] xfer_m = '0;
    int           l_cyc[$];
    int           l_gid[$];
    int           l_dat[$];
    int           busy_cnt = 0;

    always @(negedge clk) begin : model
        int           win;
        int           idx;
        bit           idle;
        logic [N-1:0] exp_rdy;
        if (chk_on) begin
            idle = (cyc >= nfree);
            win  = -1;
            if (idle && !reset) begin
                for (int k = 0; k < int'(N); k++) begin
                    idx = (ptr_m + k) % int'(N);
                    if (win < 0 && b0.req_valid[idx]) win = idx;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", 32'(b0.req_ready), 32'(exp_rdy));
            chk("ser_enable", 32'(b0.ser_enable), 32'(cyc == t_x + 1));
            chk("ser_data", 32'(b0.ser_data), 32'(hold_m));
            chk("grant_id", 32'(b0.grant_id), gid_m);
            chk("busy", 32'(b0.busy), 32'(!idle));
            if (b0.ser_enable === 1'b1) begin
                l_cyc.push_back(cyc);
                l_gid.push_back(int'(b0.grant_id));
                l_dat.push_back(int'(b0.ser_data));
            end
            if (b0.busy === 1'b1) busy_cnt++;
            xfer_m = '0;
            if (reset) begin
                t_x    = -100;
                nfree  = cyc + 1;
                ptr_m  = 0;
                gid_m  = 0;
                hold_m = 8'h00;
            end else if (win >= 0) begin
                xfer_m[win] = 1'b1;
                t_x    = cyc;
                nfree  = cyc + 2 + int'(F);
                ptr_m  = (win + 1) % int'(N);
                gid_m  = win;
                hold_m = b0.req_data[8*win +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) if (xfer_m[i]) b0.req_valid[i] = 1'b0;
    endtask

    task automatic post(input int i, input logic [7:0] d);
        b0.req_valid[i]      = 1'b1;
        b0.req_data[8*i +: 8] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_log();
        l_cyc.delete();
        l_gid.delete();
        l_dat.delete();
        busy_cnt = 0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            if (b0.req_valid == '0 && cyc > nfree) ok = 1'b1;
            else tick();
        end
        chk("drain_done", 32'(ok), 1);
    endtask

    task automatic wait_launch(input int n, input int max_cyc);
        for (int k = 0; k < max_cyc && l_cyc.size() < n; k++) tick();
        chk("launch_count", l_cyc.size(), n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(b0.req_ready), 0);
        chk({tag, "_en"}, 32'(b0.ser_enable), 0);
        chk({tag, "_data"}, 32'(b0.ser_data), 0);
        chk({tag, "_gid"}, 32'(b0.grant_id), 0);
        chk({tag, "_busy"}, 32'(b0.busy), 0);
    endtask

    initial begin : main
        int exp_ord[5];
        int t0;
        b0.req_valid = '0;
        b0.req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");

        // Single request from requester 2.
        tick();
        clear_log();
        post(2, 8'hA5);
        @(negedge clk);
        t0 = cyc;
        chk("single_ready", 32'(b0.req_ready), 32'h4);
        repeat (16) tick();
        chk("single_launches", l_cyc.size(), 1);
        chk("single_en_cycle", qget(l_cyc, 0), t0 + 1);
        chk("single_gid", qget(l_gid, 0), 2);
        chk("single_data", qget(l_dat, 0), 32'hA5);
        chk("single_busy_len", busy_cnt, 12);
        chk("single_hold", 32'(b0.ser_data), 32'hA5);

        // All four requesters continuously valid.
        do_reset();
        clear_log();
        for (int i = 0; i < 4; i++) post(i, 8'(8'h10 + i));
        for (int k = 0; k < 200 && l_cyc.size() < 5; k++) begin
            tick();
            for (int i = 0; i < 4; i++) if (!b0.req_valid[i]) post(i, 8'(8'h10 + i));
        end
        exp_ord = '{0, 1, 2, 3, 0};
        chk("rr_launches", l_cyc.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_gid", qget(l_gid, k), exp_ord[k]);
            chk("rr_data", qget(l_dat, k), 16 + exp_ord[k]);
        end
        for (int k = 1; k < 5; k++) chk("rr_spacing", qget(l_cyc, k) - qget(l_cyc, k - 1), 13);
        drain();

        // Requester 3 arrives mid-frame while requester 0 is in flight.
        do_reset();
        clear_log();
        post(0, 8'h5A);
        wait_launch(1, 40);
        repeat (3) tick();
        post(3, 8'hC3);
        @(negedge clk);
        chk("late_ready_held", 32'(b0.req_ready), 0);
        wait_launch(2, 40);
        chk("late_gid0", qget(l_gid, 0), 0);
        chk("late_gid1", qget(l_gid, 1), 3);
        chk("late_data1", qget(l_dat, 1), 32'hC3);
        chk("late_spacing", qget(l_cyc, 1) - qget(l_cyc, 0), 13);
        drain();

        // Reset pulse in the middle of a frame.
        do_reset();
        clear_log();
        post(2, 8'h66);
        wait_launch(1, 40);
        repeat (4) tick();
        do_reset();
        @(negedge clk);
        chk_reset_vals("midrst");
        tick();
        clear_log();
        post(1, 8'h77);
        post(3, 8'h88);
        wait_launch(2, 60);
        chk("midrst_gid0", qget(l_gid, 0), 1);
        chk("midrst_data0", qget(l_dat, 0), 32'h77);
        chk("midrst_gid1", qget(l_gid, 1), 3);
        chk("midrst_data1", qget(l_dat, 1), 32'h88);
        drain();

        // Pointer wrap: 0 and 3 together, then 0 alone.
        do_reset();
        clear_log();
        post(0, 8'hE0);
        post(3, 8'hE3);
        for (int k = 0; k < 200 && l_cyc.size() < 4; k++) begin
            tick();
            if (!b0.req_valid[0]) post(0, 8'hE1);
        end
        exp_ord = '{0, 3, 0, 0, 0};
        chk("wrap_launches", l_cyc.size(), 4);
        for (int k = 0; k < 4; k++) chk("wrap_gid", qget(l_gid, k), exp_ord[k]);
        drain();

        // Random traffic with occasional reset pulses.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            tick();
            reset = ($urandom_range(149) == 0);
            for (int i = 0; i < int'(N); i++) begin
                if (!b0.req_valid[i] && $urandom_range(3) == 0) post(i, 8'($urandom));
            end
        end
        tick();
        reset = 1'b0;
        drain();

        for (int k = 0; k < 500 && !done1; k++) tick();
        chk("gap_bench_done", 32'(done1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Inter-frame gap of 5: two back-to-back bytes from requester 1.
    initial begin : gap_test
        int e_cyc[$];
        int acc;
        bit got;
        b1.req_valid = '0;
        b1.req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset1          = 1'b0;
        b1.req_valid[1] = 1'b1;
        b1.req_data[15:8] = 8'h33;
        acc = 0;
        for (int k = 0; k < 120 && e_cyc.size() < 2; k++) begin
            @(negedge clk);
            if (b1.ser_enable === 1'b1) e_cyc.push_back(cyc);
            got = (b1.req_ready[1] === 1'b1) && b1.req_valid[1];
            @(posedge clk);
            #1;
            if (got) begin
                acc++;
                if (acc == 1) b1.req_data[15:8] = 8'h44;
                else b1.req_valid[1] = 1'b0;
            end
        end
        @(negedge clk);
        chk("gap_launches", e_cyc.size(), 2);
        chk("gap_spacing", qget(e_cyc, 1) - qget(e_cyc, 0), 18);
        chk("gap_accepts", acc, 2);
        chk("gap_gid", 32'(b1.grant_id), 1);
        chk("gap_data", 32'(b1.ser_data), 32'h44);
        done1 = 1'b1;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Scheduler that shares the single UART transmit serializer between `NUM_REQ` byte producers. It arbitrates round-robin among pending requesters and accepts one byte per frame. It pulses the serializer's one-cycle `enable` with the byte held stable, then blocks further launches until the frame and an optional inter-frame gap have elapsed. It sits between the command/status sources and the serializer, and is clocked and reset together with the serializer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FRAME_CYCLES`, 11: serializer cycles from start bit through stop bit.
- `GAP_CYCLES`, 0: extra idle cycles between frames, 0..255.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester byte pending.
- `req_data` in `8*NUM_REQ`: byte of requester i is `[8i+7:8i]`.
- `req_ready` out `NUM_REQ`: one-hot acceptance. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `ser_enable` out 1: one-cycle launch pulse to the serializer.
- `ser_data` out 8: byte to the serializer, held from launch until the frame ends.
- `grant_id` out `clog2(NUM_REQ)`: index of the last accepted requester.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `req_ready` is asserted combinationally for the arbiter winner only, and only while that requester's `req_valid` is high. On transfer, latch `req_data[winner]` into the hold register, set `grant_id` to the winner, advance the priority pointer to winner+1 (mod `NUM_REQ`), and go to LAUNCH. If no valid request, stay in IDLE.
  - LAUNCH: `ser_enable`=1 for exactly one cycle; go to FRAME and load the counter with `FRAME_CYCLES`-1.
  - FRAME: decrement the counter. At 0, go to GAP if `GAP_CYCLES`>0, otherwise to IDLE.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- Arbitration:
  - Search starts at the priority pointer and wraps.
  - The pointer resets to 0, so requester 0 has top priority after reset.
  - A requester granted this frame has lowest priority for the next frame.
- Handshake rules:
  - `req_valid` must stay high with stable data until it is accepted; requesters must not withdraw a pending request.
  - `req_ready` is 0 in all states except IDLE.
- `ser_data` equals the hold register at all times. The hold register changes only on a transfer in IDLE.
- Counter width is `clog2(max(FRAME_CYCLES, GAP_CYCLES)+1)`. The counter never wraps; FSM exit happens at 0.

## Timing
- Reset values: `req_ready`=0, `ser_enable`=0, `ser_data`=8'h00, `grant_id`=0, `busy`=0, state=IDLE, pointer=0.
- Transfer in cycle t:
  - `ser_enable` is high in t+1.
  - The serializer start bit is in t+2 and its stop bit in t+1+`FRAME_CYCLES`.
  - FRAME covers t+2..t+1+`FRAME_CYCLES`.
  - The earliest next transfer is t+2+`FRAME_CYCLES`+`GAP_CYCLES`.
  - With the defaults, back-to-back bytes are 13 cycles apart.
- Simultaneous requests in IDLE: exactly one winner per the pointer; the others wait, with `req_ready` low.
- A request arriving while busy is held off until IDLE; there is no loss and no buffering beyond one byte.
- Reset at any point, including mid-LAUNCH or mid-FRAME, returns the block to reset values on the next edge. The byte in flight is dropped and is not re-requested. The serializer is reset in the same cycle.
- `NUM_REQ`=1 degenerates to a pass-through with frame pacing.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, LAUNCH, FRAME, GAP);
  - `UART_FRAME_CYCLES`=11, shared with the serializer;
  - data width constant 8.
- Sub-module `rr_arbiter` (`NUM_REQ`): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and index `gnt_idx`. It is purely combinational. The pointer register lives in the scheduler.
- Top-level RTL: FSM, counter, hold register and pointer, roughly 150–250 lines total.

## Test plan
- Single request: `req_valid[2]`=1 with data 8'hA5 after reset → `req_ready[2]` high in the same cycle, `ser_enable` pulse on the next cycle, `ser_data`=8'hA5 held for 12 cycles, `grant_id`=2, `busy` low after 12 cycles.
- All 4 requesters valid continuously, data 8'h10..8'h13 → grant order 0,1,2,3,0, with launches exactly 13 cycles apart.
- Set `GAP_CYCLES`=5 and two back-to-back requests from requester 1 → second `ser_enable` 18 cycles after the first.
- Requester 3 asserts valid mid-FRAME while requester 0 is in flight → `req_ready[3]` stays low until IDLE, then is accepted with data intact.
- `reset` pulsed for 1 cycle during FRAME → all outputs at reset values on the next edge. A subsequent request from requester 1 is granted normally, with the pointer back at 0.
- Requesters 0 and 3 both valid right after reset, then only 0 repeatedly → order 0,3,0,0, with the pointer wrap verified.
